// File: rtl/pmodmic3_spi_sampler.sv
// PmodMIC3 (ADCS7476) SPI capture engine: periodic 16-clock conversions, 12-bit samples
// buffered in a first-word-fall-through FIFO with sticky overflow.
module pmodmic3_spi_sampler #(
   parameter int unsigned CLK_DIV       = 5,
   parameter int unsigned SAMPLE_PERIOD = 2500,
   parameter int unsigned FIFO_DEPTH    = 16
) (
   input  logic                              ACLK,
   input  logic                              ARESETN,
   input  logic                              enable,
   output logic                              mic_cs_n,
   output logic                              mic_sclk,
   input  logic                              mic_miso,
   output logic [11:0]                       sample_data,
   output logic                              sample_valid,
   input  logic                              sample_ready,
   output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_level,
   output logic                              overflow,
   input  logic                              overflow_clr,
   output logic                              busy
);

   localparam int unsigned AW          = $clog2(FIFO_DEPTH);
   localparam int unsigned LW          = $clog2(FIFO_DEPTH + 1);
   localparam int unsigned PW          = $clog2(SAMPLE_PERIOD);
   localparam int unsigned CW          = $clog2(CLK_DIV);
   localparam int unsigned QuietCycles = 4;

   typedef enum logic [2:0] {StIdle, StLead, StShift, StDone, StQuiet} state_e;

   state_e          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            half_q, half_d;
   logic [3:0]      bit_q, bit_d;
   logic [11:0]     shreg_q, shreg_d;
   logic [PW-1:0]   period_q, period_d;
   logic            cs_n_q, cs_n_d;
   logic            sclk_q, sclk_d;
   logic            miso_s1_q, miso_s2_q;
   logic            start, push;

   logic [11:0]     mem_q [FIFO_DEPTH];
   logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [LW-1:0]   count_q, count_d;
   logic            overflow_q, overflow_d;
   logic            full, pop, wr_en;

   assign start = (state_q == StIdle) && enable && (period_q == '0);

   always_comb begin
      period_d = '0;
      if (enable) begin
         period_d = (period_q == PW'(SAMPLE_PERIOD - 1)) ? '0 : period_q + 1'b1;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      half_d  = half_q;
      bit_d   = bit_q;
      shreg_d = shreg_q;
      push    = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (start) begin
               state_d = StLead;
               cnt_d   = '0;
            end
         end
         StLead: begin
            if (cnt_q == CW'(CLK_DIV - 1)) begin
               state_d = StShift;
               cnt_d   = '0;
               half_d  = 1'b0;
               bit_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         StShift: begin
            if (cnt_q == CW'(CLK_DIV - 1)) begin
               cnt_d = '0;
               if (!half_q) begin
                  half_d = 1'b1;
               end else begin
                  // 12-bit shifter: the four leading zeros fall off the top
                  shreg_d = {shreg_q[10:0], miso_s2_q};
                  half_d  = 1'b0;
                  if (bit_q == 4'd15) begin
                     state_d = StDone;
                  end else begin
                     bit_d = bit_q + 1'b1;
                  end
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         StDone: begin
            push    = 1'b1;
            state_d = StQuiet;
            cnt_d   = '0;
         end
         StQuiet: begin
            if (cnt_q == CW'(QuietCycles - 1)) begin
               state_d = StIdle;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // Pins are registered copies of the decoded next state, so they change with the state.
   assign cs_n_d = !((state_d == StLead) || (state_d == StShift));
   assign sclk_d = !((state_d == StShift) && !half_d);

   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         state_q   <= StIdle;
         cnt_q     <= '0;
         half_q    <= 1'b0;
         bit_q     <= '0;
         shreg_q   <= '0;
         period_q  <= '0;
         cs_n_q    <= 1'b1;
         sclk_q    <= 1'b1;
         miso_s1_q <= 1'b0;
         miso_s2_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         half_q    <= half_d;
         bit_q     <= bit_d;
         shreg_q   <= shreg_d;
         period_q  <= period_d;
         cs_n_q    <= cs_n_d;
         sclk_q    <= sclk_d;
         miso_s1_q <= mic_miso;
         miso_s2_q <= miso_s1_q;
      end
   end

   assign mic_cs_n = cs_n_q;
   assign mic_sclk = sclk_q;
   assign busy     = ~cs_n_q;

   assign full  = (count_q == LW'(FIFO_DEPTH));
   assign pop   = (count_q != '0) && sample_ready;
   // When full, a same-cycle pop frees the slot the write lands in.
   assign wr_en = push && (!full || pop);

   always_comb begin
      wr_ptr_d = wr_en ? wr_ptr_q + 1'b1 : wr_ptr_q;
      rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
      count_d  = count_q;
      unique case ({wr_en, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
      overflow_d = overflow_q;
      if (push && full && !pop) begin
         overflow_d = 1'b1;
      end else if (overflow_clr) begin
         overflow_d = 1'b0;
      end
   end

   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         overflow_q <= overflow_d;
      end
   end

   always_ff @(posedge ACLK) begin
      if (wr_en) begin
         mem_q[wr_ptr_q] <= shreg_q;
      end
   end

   assign sample_valid = (count_q != '0);
   assign sample_data  = sample_valid ? mem_q[rd_ptr_q] : '0;
   assign fifo_level   = count_q;
   assign overflow     = overflow_q;

endmodule

// File: tb/tb_pmodmic3_spi_sampler.sv
// Bench for pmodmic3_spi_sampler: ADC MISO model, pin-timing recorder and a sample scoreboard.
module tb_pmodmic3_spi_sampler;

   localparam int unsigned CLK_DIV       = 5;
   localparam int unsigned SAMPLE_PERIOD = 2500;
   localparam int unsigned FIFO_DEPTH    = 16;

   logic        ACLK = 1'b0;
   logic        ARESETN = 1'b0;
   logic        enable = 1'b0;
   logic        mic_miso = 1'b0;
   logic        sample_ready = 1'b0;
   logic        overflow_clr = 1'b0;
   logic        mic_cs_n, mic_sclk, sample_valid, overflow, busy;
   logic [11:0] sample_data;
   logic [4:0]  fifo_level;

   int checks = 0;
   int errors = 0;

   logic [11:0] exp_q[$];
   logic [15:0] miso_q[$];

   pmodmic3_spi_sampler #(
      .CLK_DIV       (CLK_DIV),
      .SAMPLE_PERIOD (SAMPLE_PERIOD),
      .FIFO_DEPTH    (FIFO_DEPTH)
   ) dut (
      .ACLK         (ACLK),
      .ARESETN      (ARESETN),
      .enable       (enable),
      .mic_cs_n     (mic_cs_n),
      .mic_sclk     (mic_sclk),
      .mic_miso     (mic_miso),
      .sample_data  (sample_data),
      .sample_valid (sample_valid),
      .sample_ready (sample_ready),
      .fifo_level   (fifo_level),
      .overflow     (overflow),
      .overflow_clr (overflow_clr),
      .busy         (busy)
   );

   initial forever #5 ACLK = ~ACLK;

   initial begin
      #1500000;
      $display("FAIL watchdog: simulation did not complete, required completion");
      $fatal(1);
   end

   // ADC model: bit (15-k) appears shortly after SCLK fall k.
   logic [15:0] cur_word = 16'h0;
   int          bitk = 0;
   always @(negedge mic_cs_n) begin
      cur_word = 16'h0;
      if (miso_q.size() > 0) cur_word = miso_q.pop_front();
      bitk = 0;
   end
   always @(negedge mic_sclk) begin
      if (!mic_cs_n && bitk < 16) begin
         #2;
         mic_miso = cur_word[4'(15 - bitk)];
         bitk++;
      end
   end

   // Pin timing recorder, sampled on the inactive clock edge.
   int cyc = 0;
   bit cs_prev = 1'b1, sclk_prev = 1'b1;
   int low_len = 0, last_low_len = 0, sclk_falls = 0, last_fall = 0, spacing_bad = 0;
   int cs_fall_cyc = 0, first_fall_off = 0;
   int cs_falls[$];
   always @(negedge ACLK) begin
      cyc++;
      if (!mic_cs_n && cs_prev) begin
         cs_falls.push_back(cyc);
         cs_fall_cyc = cyc;
         low_len     = 0;
         sclk_falls  = 0;
         spacing_bad = 0;
      end
      if (!mic_cs_n) low_len++;
      if (mic_cs_n && !cs_prev) last_low_len = low_len;
      if (!mic_sclk && sclk_prev) begin
         sclk_falls++;
         if (sclk_falls == 1) first_fall_off = cyc - cs_fall_cyc;
         else if (cyc - last_fall != 2 * CLK_DIV) spacing_bad++;
         last_fall = cyc;
      end
      cs_prev   = mic_cs_n;
      sclk_prev = mic_sclk;
   end

   // Scoreboard monitor: every accepted pop is compared with the oldest expected sample.
   logic [11:0] mon_exp;
   always @(negedge ACLK) begin
      if (ARESETN && sample_valid && sample_ready) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL pop_unexpected: got 0x%03h, required no sample", sample_data);
         end else begin
            mon_exp = exp_q.pop_front();
            if (sample_data !== mon_exp) begin
               errors++;
               $display("FAIL pop_data: got 0x%03h, required 0x%03h", sample_data, mon_exp);
            end
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
      end
   endtask

   task automatic timeout(input string name);
      checks++;
      errors++;
      $display("FAIL %s: timed out, required event not seen", name);
   endtask

   task automatic tick();
      @(posedge ACLK);
      #1;
   endtask

   task automatic wait_level(input int n, input int max, input string name);
      int i = 0;
      while (fifo_level != 5'(n) && i < max) begin
         tick();
         i++;
      end
      if (fifo_level != 5'(n)) timeout(name);
   endtask

   task automatic wait_cs_edge(input bit rising, input int max, input string name);
      logic prev = mic_cs_n;
      bit   seen = 1'b0;
      for (int i = 0; i < max && !seen; i++) begin
         tick();
         seen = rising ? (mic_cs_n && !prev) : (!mic_cs_n && prev);
         prev = mic_cs_n;
      end
      if (!seen) timeout(name);
   endtask

   task automatic wait_sclk_falls(input int n, input int max, input string name);
      int i = 0;
      do begin
         tick();
         i++;
      end while (sclk_falls < n && i < max);
      if (sclk_falls < n) timeout(name);
   endtask

   initial begin
      int base;
      repeat (3) tick();
      check("rst_cs_n", mic_cs_n, 1);
      check("rst_sclk", mic_sclk, 1);
      check("rst_busy", busy, 0);
      check("rst_valid", sample_valid, 0);
      check("rst_level", fifo_level, 0);
      check("rst_data", sample_data, 0);
      check("rst_overflow", overflow, 0);
      ARESETN = 1'b1;
      tick();

      // Single conversion of 0x0A5C, enable dropped at slot 8.
      miso_q.push_back(16'h0A5C);
      exp_q.push_back(12'hA5C);
      enable = 1'b1;
      tick();
      check("first_start_cs_n", mic_cs_n, 0);
      check("first_start_busy", busy, 1);
      wait_sclk_falls(9, 200, "slot8");
      enable = 1'b0;
      wait_cs_edge(1'b1, 300, "a_done");
      check("a_level_on_push", fifo_level, 0);
      tick();
      check("a_level_after_push", fifo_level, 1);
      check("a_cs_low_len", last_low_len, 33 * CLK_DIV);
      check("a_sclk_falls", sclk_falls, 16);
      check("a_first_fall_off", first_fall_off, CLK_DIV);
      check("a_fall_spacing_bad", spacing_bad, 0);
      check("a_head", sample_data, 12'hA5C);
      base = cs_falls.size();
      repeat (10000) tick();
      check("a_no_start_disabled", cs_falls.size() - base, 0);
      sample_ready = 1'b1;
      tick();
      sample_ready = 1'b0;
      check("a_empty_after_pop", sample_valid, 0);

      // Continuous run 001..004: start on the first enabled cycle, fixed period.
      for (int i = 1; i <= 4; i++) begin
         miso_q.push_back(16'(i));
         exp_q.push_back(12'(i));
      end
      base = cs_falls.size();
      enable = 1'b1;
      tick();
      check("reenable_start", mic_cs_n, 0);
      for (int i = 0; i < 4 * SAMPLE_PERIOD + 100 && cs_falls.size() < base + 4; i++) tick();
      enable = 1'b0;
      if (cs_falls.size() < base + 4) timeout("b_four_starts");
      else begin
         for (int i = 1; i < 4; i++)
            check("b_period", cs_falls[base + i] - cs_falls[base + i - 1], SAMPLE_PERIOD);
      end
      wait_level(4, 400, "b_level4");
      check("b_level", fifo_level, 4);
      sample_ready = 1'b1;
      repeat (4) tick();
      sample_ready = 1'b0;
      check("b_valid_drained", sample_valid, 0);
      check("b_level_drained", fifo_level, 0);
      check("b_scoreboard_empty", exp_q.size(), 0);
      repeat (10) tick();

      // Fill to 16, pop-with-push when full, then a dropped sample.
      for (int i = 1; i <= 18; i++) miso_q.push_back(16'(i));
      for (int i = 1; i <= 17; i++) exp_q.push_back(12'(i));
      enable = 1'b1;
      wait_level(16, 16 * SAMPLE_PERIOD, "c_fill");
      check("c_full_level", fifo_level, 16);
      check("c_full_no_ovf", overflow, 0);
      check("c_full_head", sample_data, 12'h001);
      wait_cs_edge(1'b1, SAMPLE_PERIOD + 200, "c_done17");
      sample_ready = 1'b1;
      tick();
      sample_ready = 1'b0;
      check("c_pushpop_level", fifo_level, 16);
      check("c_pushpop_no_ovf", overflow, 0);
      wait_cs_edge(1'b0, SAMPLE_PERIOD + 100, "c_start18");
      enable = 1'b0;
      wait_cs_edge(1'b1, 400, "c_done18");
      tick();
      check("c_drop_ovf", overflow, 1);
      check("c_drop_level", fifo_level, 16);
      check("c_drop_head", sample_data, 12'h002);
      overflow_clr = 1'b1;
      tick();
      overflow_clr = 1'b0;
      check("c_clr_ovf", overflow, 0);
      check("c_clr_level", fifo_level, 16);
      check("c_clr_head", sample_data, 12'h002);
      sample_ready = 1'b1;
      repeat (16) tick();
      sample_ready = 1'b0;
      check("c_drained_valid", sample_valid, 0);
      check("c_scoreboard_empty", exp_q.size(), 0);

      // Asynchronous reset in slot 5, then a clean capture.
      miso_q.push_back(16'h0013);
      miso_q.push_back(16'h0FFF);
      miso_q.push_back(16'h0ABC);
      exp_q.push_back(12'h013);
      enable = 1'b1;
      wait_cs_edge(1'b1, 400, "e_done19");
      tick();
      check("e_level_before_rst", fifo_level, 1);
      wait_cs_edge(1'b0, SAMPLE_PERIOD + 100, "e_start20");
      wait_sclk_falls(6, 200, "e_slot5");
      #2;
      ARESETN = 1'b0;
      #1;
      check("e_rst_cs_n", mic_cs_n, 1);
      check("e_rst_sclk", mic_sclk, 1);
      check("e_rst_busy", busy, 0);
      check("e_rst_level", fifo_level, 0);
      check("e_rst_valid", sample_valid, 0);
      check("e_rst_overflow", overflow, 0);
      exp_q.delete();
      exp_q.push_back(12'hABC);
      tick();
      ARESETN = 1'b1;
      wait_level(1, 400, "e_post_rst");
      check("e_post_rst_head", sample_data, 12'hABC);
      sample_ready = 1'b1;
      tick();
      sample_ready = 1'b0;
      enable = 1'b0;
      check("e_post_rst_empty", sample_valid, 0);
      check("e_scoreboard_empty", exp_q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
